// File: rtl/drlp_result_wb.sv
// drlp_result_wb: drains per-PE psum results from pmem, applies optional ReLU,
// packs masked-in results into DMA words and writes them out over a valid/ready port.
// Ports: i_clk/i_rst (async active-high); i_start + config (base, count, pe_mask, relu)
//   latched on start; o_pmem_rd_en/o_pmem_rd_addr read strobe, i_result returns one
//   cycle later; o_dma_wr_en/addr/data held until i_dma_wr_ready; o_busy, o_done pulse.
module drlp_result_wb #(
  parameter int PE_NUM          = 16,
  parameter int OUT_WIDTH       = 16,
  parameter int DMA_DATA_WIDTH  = 32,
  parameter int DMA_ADDR_WIDTH  = 32,
  parameter int PMEM_ADDR_WIDTH = 8
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_start,
  input  logic [DMA_ADDR_WIDTH-1:0]     i_base_addr,
  input  logic [PMEM_ADDR_WIDTH:0]      i_count,
  input  logic [PE_NUM-1:0]             i_pe_mask,
  input  logic                          i_relu,
  input  logic [PE_NUM*OUT_WIDTH-1:0]   i_result,
  output logic                          o_pmem_rd_en,
  output logic [PMEM_ADDR_WIDTH-1:0]    o_pmem_rd_addr,
  output logic                          o_dma_wr_en,
  output logic [DMA_ADDR_WIDTH-1:0]     o_dma_wr_addr,
  output logic [DMA_DATA_WIDTH-1:0]     o_dma_wr_data,
  input  logic                          i_dma_wr_ready,
  output logic                          o_busy,
  output logic                          o_done
);

  localparam int LANES = DMA_DATA_WIDTH / OUT_WIDTH;
  localparam int PW    = (PE_NUM > 1) ? $clog2(PE_NUM) : 1;
  localparam int LW    = $clog2(LANES + 1);
  localparam int BYTES = DMA_DATA_WIDTH / 8;

  typedef enum logic [2:0] {
    S_IDLE, S_READ, S_CAPTURE, S_DRAIN, S_FLUSH, S_DONE
  } state_t;

  state_t state, state_nx;

  logic [PMEM_ADDR_WIDTH:0]      cfg_count;
  logic [PE_NUM-1:0]             cfg_mask;
  logic                          cfg_relu;
  logic [PMEM_ADDR_WIDTH-1:0]    rd_addr;
  logic [PW-1:0]                 pe_idx;
  logic [LW-1:0]                 lane_cnt;
  logic [DMA_DATA_WIDTH-1:0]     pack;
  logic [PE_NUM*OUT_WIDTH-1:0]   cap;
  logic                          wr_vld;
  logic [DMA_ADDR_WIDTH-1:0]     wr_addr;
  logic [DMA_DATA_WIDTH-1:0]     wr_data;

  // The output slot can take a new word if empty or being emptied this cycle.
  logic accept, slot_free;
  assign accept    = wr_vld & i_dma_wr_ready;
  assign slot_free = ~wr_vld | i_dma_wr_ready;

  logic                      last_pe, last_addr, pe_in;
  logic                      drain_step, load_word, flush_load;
  logic [OUT_WIDTH-1:0]      pe_val;
  logic [DMA_DATA_WIDTH-1:0] pack_ins;

  assign last_pe   = (pe_idx == PW'(PE_NUM - 1));
  assign last_addr = ({1'b0, rd_addr} == cfg_count - 1'b1);
  assign pe_in     = cfg_mask[pe_idx];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    drain_step = 1'b0;
    load_word  = 1'b0;
    flush_load = 1'b0;

    pe_val = cap[pe_idx*OUT_WIDTH +: OUT_WIDTH];
    if (cfg_relu && pe_val[OUT_WIDTH-1]) pe_val = '0;
    pack_ins = pack;
    pack_ins[lane_cnt*OUT_WIDTH +: OUT_WIDTH] = pe_val;

    case (state)
      S_IDLE: begin
        if (i_start) state_nx = (i_count == '0) ? S_DONE : S_READ;
      end
      S_READ:    state_nx = S_CAPTURE;
      S_CAPTURE: state_nx = S_DRAIN;
      S_DRAIN: begin
        // Every index, masked or not, waits for the slot so word order is preserved.
        if (slot_free) begin
          drain_step = 1'b1;
          load_word  = pe_in && (lane_cnt == LW'(LANES - 1));
          if (last_pe) state_nx = last_addr ? S_FLUSH : S_READ;
        end
      end
      S_FLUSH: begin
        if (lane_cnt != '0) begin
          if (slot_free) flush_load = 1'b1;
        end else if (slot_free) begin
          state_nx = S_DONE;
        end
      end
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cfg_count <= '0;
      cfg_mask  <= '0;
      cfg_relu  <= 1'b0;
      rd_addr   <= '0;
      pe_idx    <= '0;
      lane_cnt  <= '0;
      pack      <= '0;
      cap       <= '0;
      wr_vld    <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
    end else begin
      if (state == S_IDLE && i_start) begin
        cfg_count <= i_count;
        cfg_mask  <= i_pe_mask;
        cfg_relu  <= i_relu;
        wr_addr   <= i_base_addr;
        rd_addr   <= '0;
        pe_idx    <= '0;
        lane_cnt  <= '0;
        pack      <= '0;
      end

      if (state == S_CAPTURE) begin
        cap    <= i_result;
        pe_idx <= '0;
      end

      if (drain_step) begin
        pe_idx <= last_pe ? '0 : pe_idx + 1'b1;
        if (last_pe && !last_addr) rd_addr <= rd_addr + 1'b1;
        if (pe_in) begin
          if (load_word) begin
            pack     <= '0;
            lane_cnt <= '0;
          end else begin
            pack     <= pack_ins;
            lane_cnt <= lane_cnt + LW'(1);
          end
        end
      end

      if (flush_load) begin
        pack     <= '0;
        lane_cnt <= '0;
      end

      // Address advances on acceptance, so a word loaded in the same cycle
      // already carries the next address.
      if (accept) wr_addr <= wr_addr + DMA_ADDR_WIDTH'(BYTES);

      if (load_word) begin
        wr_vld  <= 1'b1;
        wr_data <= pack_ins;
      end else if (flush_load) begin
        wr_vld  <= 1'b1;
        wr_data <= pack;
      end else if (accept) begin
        wr_vld  <= 1'b0;
      end
    end
  end

  assign o_pmem_rd_en   = (state == S_READ);
  assign o_pmem_rd_addr = rd_addr;
  assign o_dma_wr_en    = wr_vld;
  assign o_dma_wr_addr  = wr_addr;
  assign o_dma_wr_data  = wr_data;
  assign o_busy         = (state != S_IDLE);
  assign o_done         = (state == S_DONE);

endmodule

// File: doc/drlp_result_wb.md
DRLP_RESULT_WB -- requirements
Module: drlp_result_wb

Interface
REQ-001 Parameter PE_NUM, default 16, number of PE result channels drained.
REQ-002 Parameter OUT_WIDTH, default 16, width of one PE result.
REQ-003 Parameter DMA_DATA_WIDTH, default 32, DMA write word width; SHALL be an integer multiple of OUT_WIDTH; LANES = DMA_DATA_WIDTH/OUT_WIDTH.
REQ-004 Parameter DMA_ADDR_WIDTH, default 32, DMA byte-address width.
REQ-005 Parameter PMEM_ADDR_WIDTH, default 8, psum memory address width.
REQ-006 The block SHALL use one clock; reset is asynchronous and active-high. Port list:
- i_clk  in  1  clock, rising edge
- i_rst  in  1  async active-high reset
- i_start  in  1  one-cycle start pulse
- i_base_addr  in  DMA_ADDR_WIDTH  first DMA byte address
- i_count  in  PMEM_ADDR_WIDTH+1  pmem addresses to drain
- i_pe_mask  in  PE_NUM  bit p=1: drain PE p
- i_relu  in  1  1: clamp negative results to 0
- i_result  in  PE_NUM*OUT_WIDTH  PE p result at bits [p*OUT_WIDTH +: OUT_WIDTH]
- o_pmem_rd_en  out  1  pmem read strobe, broadcast to all PEs
- o_pmem_rd_addr  out  PMEM_ADDR_WIDTH  pmem read address
- o_dma_wr_en  out  1  write request (valid)
- o_dma_wr_addr  out  DMA_ADDR_WIDTH  write byte address
- o_dma_wr_data  out  DMA_DATA_WIDTH  packed write data
- i_dma_wr_ready  in  1  DMA accepts word
- o_busy  out  1  high in every state except IDLE
- o_done  out  1  one-cycle completion pulse

Function
REQ-007 States: IDLE, READ, CAPTURE, DRAIN, FLUSH, DONE.
REQ-008 IDLE + i_start: latch i_base_addr, i_count, i_pe_mask, i_relu; rd address counter = 0; PE index = 0; lane count = 0; next state READ, or DONE if i_count==0.
REQ-009 i_start in any non-IDLE state SHALL be ignored; latched configuration SHALL NOT change mid-operation.
REQ-010 READ (one cycle): o_pmem_rd_en=1, o_pmem_rd_addr=current address; then CAPTURE.
REQ-011 CAPTURE (one cycle): latch all PE_NUM entries of i_result (one-cycle pmem read latency); then DRAIN with PE index 0.
REQ-012 DRAIN visits PE index 0..PE_NUM-1 in ascending order, one index per advancing cycle; masked-off indices consume one cycle and pack nothing.
REQ-013 A masked-in result, after ReLU (if relu latched and MSB=1, value=0; else unchanged), SHALL be placed in lane lane_count (lane 0 = bits [OUT_WIDTH-1:0]); lane_count increments.
REQ-014 When lane_count reaches LANES, the packed word SHALL be moved to the output register, o_dma_wr_en=1, lane_count=0, the packing register cleared to 0.
REQ-015 Handshake: transfer occurs on a rising edge with o_dma_wr_en=1 and i_dma_wr_ready=1; o_dma_wr_addr and o_dma_wr_data SHALL remain stable while o_dma_wr_en=1 and not accepted; o_dma_wr_en drops after the transfer unless a new word is loaded in the same cycle.
REQ-016 DRAIN SHALL advance only when the output slot is free (o_dma_wr_en=0) or is accepted in that cycle; otherwise it stalls, holding PE index.
REQ-017 The write address starts at the latched base and increments by DMA_DATA_WIDTH/8 after each accepted word, wrapping modulo 2^DMA_ADDR_WIDTH.
REQ-018 After PE index PE_NUM-1: if address == count-1, go to FLUSH; else increment address and go to READ.
REQ-019 FLUSH: if lane_count>0, emit the partial word with unused upper lanes 0 (subject to REQ-016); wait until no word is pending; then DONE.
REQ-020 DONE (one cycle): o_done=1; next state IDLE.
REQ-021 i_pe_mask==0: no DMA writes; reads still issued for all addresses; o_done still pulses.

Reset
REQ-022 i_rst asserted SHALL immediately force IDLE and all outputs to 0, including o_dma_wr_en, o_busy, o_done, o_pmem_rd_en, and both address outputs; the packing state, counters, and latched configuration SHALL be cleared to 0.
REQ-023 Reset mid-operation SHALL discard any pending word without a transfer; the next i_start after release SHALL begin a fresh operation.

Verification
REQ-024 Defaults; mask=16'h0003, count=2, relu=0, base=0x100, ready tied 1; PE0/PE1 results 0x1111/0x2222 at addr 0 and 0x3333/0x4444 at addr 1 -> writes 0x22221111@0x100, 0x44443333@0x104; o_done pulses once.
REQ-025 mask=16'h0001, count=3, results 0x000A,0x000B,0x000C -> 0x000B000A@base, 0x0000000C@base+4 (flush); exactly 2 writes.
REQ-026 relu=1, PE0=0x8005, PE1=0x7FFF -> word 0x7FFF0000; with relu=0 -> 0x7FFF8005.
REQ-027 i_dma_wr_ready held 0 for 5 cycles while o_dma_wr_en=1 -> addr/data stable, DRAIN stalls, no words lost or duplicated; i_start during busy is ignored.
REQ-028 count=0 -> o_done one cycle after start, no rd_en, no writes; i_rst mid-DRAIN with word pending -> all outputs 0 immediately, no transfer, new start runs cleanly.
